vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of core requesters.
REQ-002 SHALL have parameter ADDR_W, default 16, VRAM word address width.
REQ-003 SHALL have parameter DATA_W, default 8, VRAM data width.
REQ-004 SHALL have parameter MAX_BURST, default 4, max consecutive grants to one locked core (range 1..15).
REQ-005 SHALL have these ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-low (0 = reset).
- core_req  in  NUM_CORES  per-core access request, level, held until granted.
- core_we  in  NUM_CORES  per-core 1 = write, 0 = read.
- core_lock  in  NUM_CORES  per-core request to keep grant for the next beat.
- core_addr  in  NUM_CORES*ADDR_W  flattened; core i at [i*ADDR_W +: ADDR_W].
- core_wdata  in  NUM_CORES*DATA_W  flattened as core_addr.
- core_gnt  out  NUM_CORES  one-hot grant pulse; access performed that cycle.
- core_rvalid  out  NUM_CORES  one-hot read-data-valid.
- core_rdata  out  DATA_W  shared read data, qualified by core_rvalid.
- vga_req  in  1  VGA scanout read request.
- vga_addr  in  ADDR_W  VGA read address.
- vga_gnt  out  1  VGA grant pulse.
- vga_rvalid  out  1  VGA read-data-valid; data on core_rdata.
- mem_en  out  1  VRAM port enable.
- mem_we  out  1  VRAM write enable.
- mem_addr  out  ADDR_W  VRAM address.
- mem_wdata  out  DATA_W  VRAM write data.
- mem_rdata  in  DATA_W  VRAM read data, valid 1 cycle after mem_en & ~mem_we.

Function
REQ-006 SHALL issue at most one VRAM access per cycle; mem_en equals OR of core_gnt and vga_gnt, same cycle (combinational grant, 0-cycle latency).
REQ-007 SHALL drive mem_we/mem_addr/mem_wdata from the granted requester; when none granted, mem_we=0, mem_addr/mem_wdata=0.
REQ-008 SHALL return read data exactly 1 cycle after grant: rvalid of the requester granted in cycle N pulses in N+1 with core_rdata = mem_rdata; writes produce no rvalid.
REQ-009 SHALL arbitrate cores round-robin: rr_ptr holds last-granted core; search starts at rr_ptr+1 modulo NUM_CORES, wrapping.
REQ-010 SHALL update rr_ptr to the granted core index on every core grant; unchanged otherwise.
REQ-011 SHALL implement FSM: IDLE (no owner), OWN (owner core holds lock), with beat counter burst_cnt (4 bits).
REQ-012 IDLE->OWN when a granted core has core_lock=1; owner := that core, burst_cnt := 1.
REQ-013 In OWN, owner SHALL be granted whenever core_req[owner]=1 and higher-priority source absent; burst_cnt increments per owner grant.
REQ-014 OWN->IDLE when owner granted with core_lock=0, or burst_cnt reaches MAX_BURST on a grant, or core_req[owner]=0; no grant to other cores in the releasing cycle only if owner granted.
REQ-015 In OWN, other cores SHALL NOT be granted while owner requests; owner dropping core_req releases in that cycle and round-robin arbitration applies immediately.
REQ-016 Dropping core_req before grant SHALL be legal; no grant or rvalid results.
REQ-017 Simultaneous core_gnt and vga_gnt SHALL never occur; core_gnt SHALL be one-hot or zero.
REQ-018 core_rvalid and vga_rvalid SHALL never be asserted together.

Reset
REQ-019 While reset=0 at posedge: core_gnt=0, core_rvalid=0, vga_gnt=0, vga_rvalid=0, mem_en=0, state=IDLE, rr_ptr=NUM_CORES-1 (first search starts at core 0), burst_cnt=0.
REQ-020 Reset mid-operation SHALL cancel any pending rvalid; grants are masked in cycles where reset=0.

Configuration
REQ-021 Macro VRAM_ARB_VGA_PRIO_EN defined: vga_req has strict priority over all cores, including a locked owner (lock and burst_cnt held, owner resumes next free cycle).
REQ-022 Macro VRAM_ARB_VGA_PRIO_EN undefined: VGA is round-robin slot index NUM_CORES in a NUM_CORES+1 ring, never locks, and cannot preempt an owner in OWN.

Verification
REQ-023 After reset, core_req=4'b0101, all reads, no lock -> gnt 0001, 0100, 0001, 0100 on successive cycles; each rvalid one cycle later with mem_rdata.
REQ-024 Core 2 req+lock, MAX_BURST=4, cores 0,1 requesting -> core 2 granted 4 consecutive cycles, then core 0 next (rr from 3 wraps to 0).
REQ-025 PRIO_EN defined, core 1 locked, vga_req pulses 1 cycle at beat 2 -> vga_gnt that cycle, core 1 resumes, total core 1 grants = 4.
REQ-026 PRIO_EN undefined, all 4 cores + vga requesting continuously -> grant order 0,1,2,3,VGA repeating.
REQ-027 Core 3 write addr 0x1234 data 0xA5 -> mem_en=1, mem_we=1, mem_addr=0x1234, mem_wdata=0xA5 same cycle, no rvalid.
REQ-028 Read granted, reset=0 next cycle -> core_rvalid stays 0, all outputs at reset values.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter for NUM_CORES core requesters plus a
// VGA scanout reader. Grants are combinational (access in the grant cycle);
// read data returns one cycle later on the shared core_rdata bus.
// A core may lock the port for up to MAX_BURST consecutive beats.
// Optional feature macro: VRAM_ARB_VGA_PRIO_EN
//   defined   -> VGA has strict priority, even over a locked owner
//   undefined -> VGA is ring slot NUM_CORES in round-robin, never preempts an owner
module vram_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES-1:0]        core_lock,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [DATA_W-1:0]           core_rdata,
  input  logic                        vga_req,
  input  logic [ADDR_W-1:0]           vga_addr,
  output logic                        vga_gnt,
  output logic                        vga_rvalid,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int SLOTS = NUM_CORES + 1;
  localparam int PTR_W = $clog2(SLOTS);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [NUM_CORES-1:0] owner_q, owner_d;        // one-hot owner core
  logic [3:0]           burst_cnt_q, burst_cnt_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_CORES-1:0] rvalid_core_q;
  logic                 rvalid_vga_q;

  logic [SLOTS-1:0]     req_vec_s;
  logic [SLOTS-1:0]     rr_onehot_s;
  logic                 rr_found_s;
  logic [PTR_W-1:0]     rr_slot_s;
  logic [SLOTS-1:0]     full_gnt_s;
  logic [PTR_W-1:0]     gnt_idx_s;
  logic                 vga_prio_s;
  logic                 ptr_upd_s;
  logic                 owner_req_s;
  logic                 owner_lock_s;
  logic                 owner_gnt_s;
  logic                 take_lock_s;
  logic                 burst_done_s;
  logic                 mem_we_s;
  logic [ADDR_W-1:0]    mem_addr_s;
  logic [DATA_W-1:0]    mem_wdata_s;

`ifdef VRAM_ARB_VGA_PRIO_EN
  // VGA bypasses the ring; only core grants move the pointer
  assign vga_prio_s = vga_req;
  assign req_vec_s  = {1'b0, core_req};
  assign ptr_upd_s  = |full_gnt_s[NUM_CORES-1:0];
`else
  // VGA takes the extra ring slot and moves the pointer like a core
  assign vga_prio_s = 1'b0;
  assign req_vec_s  = {vga_req, core_req};
  assign ptr_upd_s  = |full_gnt_s;
`endif

  assign owner_req_s  = |(core_req & owner_q);
  assign owner_lock_s = |(core_lock & owner_q);
  assign owner_gnt_s  = |(full_gnt_s[NUM_CORES-1:0] & owner_q);
  assign take_lock_s  = (|(full_gnt_s[NUM_CORES-1:0] & core_lock)) && (MAX_BURST > 1);
  assign burst_done_s = (burst_cnt_q + 4'd1) >= 4'(MAX_BURST);

  // State, pointer and read-valid registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      burst_cnt_q   <= 4'd0;
      rr_ptr_q      <= PTR_W'(NUM_CORES - 1);
      rvalid_core_q <= '0;
      rvalid_vga_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      burst_cnt_q   <= burst_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      rvalid_core_q <= full_gnt_s[NUM_CORES-1:0] & ~core_we;
      rvalid_vga_q  <= full_gnt_s[NUM_CORES];
    end
  end

  // Round-robin search starting one slot after the last grant, wrapping
  always_comb begin
    rr_onehot_s = '0;
    rr_found_s  = 1'b0;
    rr_slot_s   = '0;
    for (int k = 1; k <= SLOTS; k++) begin
      rr_slot_s = PTR_W'((int'(rr_ptr_q) + k) % SLOTS);
      if (!rr_found_s && req_vec_s[rr_slot_s]) begin
        rr_onehot_s[rr_slot_s] = 1'b1;
        rr_found_s             = 1'b1;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // FSM next state: lock acquisition, burst counting and release
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (take_lock_s) begin
          state_d     = OWN;
          owner_d     = full_gnt_s[NUM_CORES-1:0];
          burst_cnt_d = 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        if (!owner_req_s) begin
          // owner gave up: the cycle was arbitrated freely and may start a new lock
          if (take_lock_s) begin
            owner_d     = full_gnt_s[NUM_CORES-1:0];
            burst_cnt_d = 4'd1;
          end else begin
            state_d     = IDLE;
            owner_d     = '0;
            burst_cnt_d = 4'd0;
          end
        end else if (owner_gnt_s) begin
          if (!owner_lock_s || burst_done_s) begin
            state_d     = IDLE;
            owner_d     = '0;
            burst_cnt_d = 4'd0;
          end else begin
            burst_cnt_d = burst_cnt_q + 4'd1;
          end
        end else begin
          // preempted by VGA: lock and beat count held
          state_d = OWN;
        end
      end
      default: begin
        state_d     = IDLE;
        owner_d     = '0;
        burst_cnt_d = 4'd0;
      end
    endcase
  end

  // Grant selection: reset mask, VGA priority, locked owner, then round-robin
  always_comb begin
    if (!reset) begin
      full_gnt_s = '0;
    end else if (vga_prio_s) begin
      full_gnt_s            = '0;
      full_gnt_s[NUM_CORES] = 1'b1;
    end else if (state_q == OWN && owner_req_s) begin
      full_gnt_s = {1'b0, owner_q};
    end else begin
      full_gnt_s = rr_onehot_s;
    end
  end

  // Encode the granted slot so the pointer records the last winner
  always_comb begin
    gnt_idx_s = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (full_gnt_s[i]) begin
        gnt_idx_s = PTR_W'(i);
      end else begin
        gnt_idx_s = gnt_idx_s;
      end
    end
    if (ptr_upd_s) begin
      rr_ptr_d = gnt_idx_s;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Memory port mux: AND-OR of the one-hot grant, all zero when idle
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = vga_addr & {ADDR_W{full_gnt_s[NUM_CORES]}};
    mem_wdata_s = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      mem_we_s    = mem_we_s    | (core_we[i] & full_gnt_s[i]);
      mem_addr_s  = mem_addr_s  | (core_addr[i*ADDR_W +: ADDR_W]  & {ADDR_W{full_gnt_s[i]}});
      mem_wdata_s = mem_wdata_s | (core_wdata[i*DATA_W +: DATA_W] & {DATA_W{full_gnt_s[i]}});
    end
  end

  assign core_gnt    = full_gnt_s[NUM_CORES-1:0];
  assign vga_gnt     = full_gnt_s[NUM_CORES];
  assign mem_en      = |full_gnt_s;
  assign mem_we      = mem_we_s;
  assign mem_addr    = mem_addr_s;
  assign mem_wdata   = mem_wdata_s;
  // read-valids are masked while reset is low so a pending return is cancelled
  assign core_rvalid = rvalid_core_q & {NUM_CORES{reset}};
  assign vga_rvalid  = rvalid_vga_q & reset;
  assign core_rdata  = ((|core_rvalid) || vga_rvalid) ? mem_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter with a scoreboard of expected read returns.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, we, lock;
  logic [15:0] a [4];
  logic [7:0]  wd [4];
  logic [15:0] vaddr;
  logic        vreq;
  logic [3:0]  core_gnt, core_rvalid;
  logic [7:0]  core_rdata;
  logic        vga_gnt, vga_rvalid, mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [63:0] core_addr_f;
  logic [31:0] core_wdata_f;

  typedef struct {
    logic [3:0] rv;
    logic       vrv;
    logic [7:0] data;
  } exp_t;
  exp_t sb [$];

  int total = 0;
  int passed = 0;
  int fails = 0;

  assign core_addr_f  = {a[3], a[2], a[1], a[0]};
  assign core_wdata_f = {wd[3], wd[2], wd[1], wd[0]};

  always #5 clk = ~clk;

  // VRAM model: registered read, data derived from the address
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem_addr[7:0] ^ 8'h5A;
  end

  vram_arbiter dut (
    .clk(clk), .reset(reset),
    .core_req(req), .core_we(we), .core_lock(lock),
    .core_addr(core_addr_f), .core_wdata(core_wdata_f),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .vga_req(vreq), .vga_addr(vaddr), .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: check grants/port this cycle, check returns of the previous one
  task automatic cycle(input string tag, input logic [3:0] eg, input logic ev);
    exp_t        e;
    logic [15:0] ea;
    logic [7:0]  ewd;
    logic        ewe;
    @(negedge clk);
    ea = 16'h0000; ewd = 8'h00; ewe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (eg[i]) begin
        ea = a[i]; ewd = wd[i]; ewe = we[i];
      end
    end
    if (ev) ea = vaddr;
    check({tag, ".gnt"},    32'(core_gnt),  32'(eg));
    check({tag, ".vgnt"},   32'(vga_gnt),   32'(ev));
    check({tag, ".en"},     32'(mem_en),    32'((eg != 4'd0) || ev));
    check({tag, ".we"},     32'(mem_we),    32'(ewe));
    check({tag, ".addr"},   32'(mem_addr),  32'(ea));
    check({tag, ".wdata"},  32'(mem_wdata), 32'(ewd));
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'(sb.size()), 32'd1);
      e.rv = 4'd0; e.vrv = 1'b0; e.data = 8'h00;
    end else begin
      e = sb.pop_front();
    end
    if (!reset) begin
      e.rv = 4'd0; e.vrv = 1'b0;
    end
    check({tag, ".rvalid"},  32'(core_rvalid), 32'(e.rv));
    check({tag, ".vrvalid"}, 32'(vga_rvalid),  32'(e.vrv));
    if (e.rv != 4'd0 || e.vrv) check({tag, ".rdata"}, 32'(core_rdata), 32'(e.data));
    e.rv = eg & ~we; e.vrv = ev; e.data = ea[7:0] ^ 8'h5A;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t z;
    int   slot;
    reset = 1'b0; req = 4'd0; we = 4'd0; lock = 4'd0; vreq = 1'b0;
    vaddr = 16'h2044;
    for (int i = 0; i < 4; i++) begin
      a[i]  = 16'h1000 + 16'(i * 16'h0011);
      wd[i] = 8'h00;
    end
    z.rv = 4'd0; z.vrv = 1'b0; z.data = 8'h00;
    sb.push_back(z);
    @(posedge clk); #1;

    // grants masked during reset
    req = 4'b0101;
    cycle("rst0", 4'b0000, 1'b0);
    cycle("rst1", 4'b0000, 1'b0);

    // plain round-robin between cores 0 and 2
    reset = 1'b1;
    cycle("rr0", 4'b0001, 1'b0);
    cycle("rr1", 4'b0100, 1'b0);
    cycle("rr2", 4'b0001, 1'b0);
    cycle("rr3", 4'b0100, 1'b0);

    // core 3 write: no read return
    req = 4'b1000; we = 4'b1000; a[3] = 16'h1234; wd[3] = 8'hA5;
    cycle("wr", 4'b1000, 1'b0);
    req = 4'd0; we = 4'd0; wd[3] = 8'h00;
    cycle("wr_idle", 4'b0000, 1'b0);

    // locked burst of MAX_BURST beats, then rr continues from core 2
    req = 4'b0100; lock = 4'b0100;
    cycle("bst0", 4'b0100, 1'b0);
    req = 4'b0111;
    cycle("bst1", 4'b0100, 1'b0);
    cycle("bst2", 4'b0100, 1'b0);
    cycle("bst3", 4'b0100, 1'b0);
    cycle("bst4", 4'b0001, 1'b0);
    req = 4'b0110;
    cycle("bst5", 4'b0010, 1'b0);
    req = 4'd0; lock = 4'd0;

    // owner blocks others, then dropping its request releases at once
    req = 4'b0011; lock = 4'b0001;
    cycle("od0", 4'b0001, 1'b0);
    cycle("od1", 4'b0001, 1'b0);
    req = 4'b0010;
    cycle("od2", 4'b0010, 1'b0);
    req = 4'd0; lock = 4'd0;

    // owner granted with lock low releases after that beat
    req = 4'b1000; lock = 4'b1000;
    cycle("ld0", 4'b1000, 1'b0);
    req = 4'b1001; lock = 4'b0000;
    cycle("ld1", 4'b1000, 1'b0);
    req = 4'b0001;
    cycle("ld2", 4'b0001, 1'b0);
    req = 4'd0;

`ifdef VRAM_ARB_VGA_PRIO_EN
    // VGA preempts a locked owner; owner still gets MAX_BURST beats in total
    req = 4'b0010; lock = 4'b0010;
    cycle("pr0", 4'b0010, 1'b0);
    vreq = 1'b1;
    cycle("pr1", 4'b0000, 1'b1);
    vreq = 1'b0;
    cycle("pr2", 4'b0010, 1'b0);
    cycle("pr3", 4'b0010, 1'b0);
    cycle("pr4", 4'b0010, 1'b0);
    req = 4'd0; lock = 4'd0;
    cycle("pr5", 4'b0000, 1'b0);
`else
    // five-slot ring: 1,2,3,VGA,0,... starting after last grant (core 0)
    req = 4'b1111; vreq = 1'b1;
    for (int k = 0; k < 10; k++) begin
      slot = (1 + k) % 5;
      cycle($sformatf("ring%0d", k), (slot < 4) ? 4'(4'b0001 << slot) : 4'b0000, slot == 4);
    end
    // VGA cannot preempt a locked owner
    req = 4'b0010; lock = 4'b0010;
    cycle("np0", 4'b0010, 1'b0);
    cycle("np1", 4'b0010, 1'b0);
    lock = 4'b0000;
    cycle("np2", 4'b0010, 1'b0);
    req = 4'd0;
    cycle("np3", 4'b0000, 1'b1);
    vreq = 1'b0;
`endif

    // request withdrawn before grant: nothing happens
    req = 4'b0011;
    cycle("dg0", 4'b0001, 1'b0);
    req = 4'b0000;
    cycle("dg1", 4'b0000, 1'b0);
    cycle("dg2", 4'b0000, 1'b0);

    // reset right after a read grant cancels the return
    req = 4'b0100;
    cycle("rg", 4'b0100, 1'b0);
    reset = 1'b0;
    cycle("rg_rst", 4'b0000, 1'b0);
    reset = 1'b1; req = 4'b0101;
    cycle("post", 4'b0001, 1'b0);
    req = 4'd0;
    cycle("end", 4'b0000, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
